// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage load/store with ready handshake, timeout and lane steering.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        access_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d, we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic        access, bad_f3, misal, legal;
  logic [31:0] shifted, ext;
  logic [15:0] half_sel;
  always_comb begin
    access   = mem_read | mem_write;
    bad_f3   = mem_write ? (funct3 > 3'b010) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misal    = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    legal    = access && !bad_f3 && !misal;
    shifted  = dm_rdata >> {lo_q, 3'b000};
    half_sel = lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ext      = f3_q[1] ? dm_rdata
             : f3_q[0] ? {{16{~f3_q[2] & half_sel[15]}}, half_sel}
             : {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    we_d     = we_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ld_d     = ld_q;
    case (state_q)
      IDLE: if (legal) begin
        state_d = REQ;
        addr_d  = {addr[31:2], 2'b00};
        we_d    = mem_write;
        f3_d    = funct3;
        lo_d    = addr[1:0];
        cnt_d   = 8'd0;
        abort_d = 1'b0;
        wstrb_d = !mem_write ? 4'b0000 : funct3[1] ? 4'b1111
                : funct3[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        wdata_d = !mem_write ? 32'd0 : funct3[1] ? wdata
                : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
      end
      REQ: if (dm_ready) begin
        state_d = DONE;
        ld_d    = we_q ? 32'd0 : ext;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = DONE;
        abort_d = 1'b1;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end
  // Gating with rst lets stall/access_err fall immediately even while the stage inputs stay asserted.
  assign stall      = !rst && (state_q == REQ || (state_q == IDLE && legal));
  assign access_err = !rst && state_q == IDLE && access && !legal;
  assign dm_req     = state_q == REQ;
  assign ld_valid   = state_q == DONE && !abort_q && !we_q;
  assign bus_err    = state_q == DONE && abort_q;
  assign ld_data    = ld_valid ? ld_q : 32'd0;
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_wstrb   = wstrb_q;
  assign dm_wdata   = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of loads, stores, illegal accesses, wait states, timeout and reset.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, dm_ready = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0, dm_rdata = '0;
  logic        stall, ld_valid, access_err, bus_err, dm_req, dm_we;
  logic [31:0] ld_data, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        stall4, ld_valid4, access_err4, bus_err4, dm_req4, dm_we4;
  logic [31:0] ld_data4, dm_addr4, dm_wdata4;
  logic [3:0]  dm_wstrb4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  load_store_unit u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .access_err(access_err), .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata)
  );
  load_store_unit #(.TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall4), .ld_valid(ld_valid4), .ld_data(ld_data4),
    .access_err(access_err4), .bus_err(bus_err4), .dm_req(dm_req4), .dm_we(dm_we4),
    .dm_addr(dm_addr4), .dm_wstrb(dm_wstrb4), .dm_wdata(dm_wdata4),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0; dm_ready = 1'b0;
  endtask
  task automatic pulse_rst();
    step(); rst = 1'b1; idle_inputs();
    step(); rst = 1'b0;
  endtask
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    step(); mem_read = 1'b1; funct3 = f3; addr = a; dm_rdata = rd; dm_ready = 1'b1; #1;
    chk({tag, " c0 stall"}, 32'(stall), 32'd1);
    chk({tag, " c0 req"}, 32'(dm_req), 32'd0);
    step(); #1;
    chk({tag, " c1 req"}, 32'(dm_req), 32'd1);
    chk({tag, " c1 stall"}, 32'(stall), 32'd1);
    chk({tag, " c1 addr"}, dm_addr, {a[31:2], 2'b00});
    chk({tag, " c1 wstrb"}, 32'(dm_wstrb), 32'd0);
    chk({tag, " c1 we"}, 32'(dm_we), 32'd0);
    step(); #1;
    chk({tag, " c2 ld_valid"}, 32'(ld_valid), 32'd1);
    chk({tag, " c2 ld_data"}, ld_data, exp);
    chk({tag, " c2 stall"}, 32'(stall), 32'd0);
    idle_inputs();
    step(); #1;
    chk({tag, " c3 ld_valid"}, 32'(ld_valid), 32'd0);
    chk({tag, " c3 req"}, 32'(dm_req), 32'd0);
  endtask
  task automatic run_store(input string tag, input logic rd, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    step(); mem_read = rd; mem_write = 1'b1; funct3 = f3; addr = a; wdata = wd; dm_ready = 1'b1; #1;
    chk({tag, " c0 stall"}, 32'(stall), 32'd1);
    step(); #1;
    chk({tag, " c1 req"}, 32'(dm_req), 32'd1);
    chk({tag, " c1 we"}, 32'(dm_we), 32'd1);
    chk({tag, " c1 addr"}, dm_addr, {a[31:2], 2'b00});
    chk({tag, " c1 wstrb"}, 32'(dm_wstrb), 32'(exp_strb));
    chk({tag, " c1 wdata"}, dm_wdata, exp_wd);
    step(); #1;
    chk({tag, " c2 ld_valid"}, 32'(ld_valid), 32'd0);
    chk({tag, " c2 stall"}, 32'(stall), 32'd0);
    idle_inputs();
  endtask
  task automatic run_illegal(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a);
    step(); mem_read = rd; mem_write = wr; funct3 = f3; addr = a; #1;
    chk({tag, " err"}, 32'(access_err), 32'd1);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    idle_inputs();
    step(); #1;
    chk({tag, " no req"}, 32'(dm_req), 32'd0);
    chk({tag, " err drop"}, 32'(access_err), 32'd0);
  endtask
  initial begin
    int n;
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req", 32'(dm_req), 32'd0);
    chk("rst flags", {29'd0, ld_valid, access_err, bus_err}, 32'd0);
    chk("rst ld_data", ld_data, 32'd0);
    chk("rst wstrb", 32'(dm_wstrb), 32'd0);
    chk("rst we", 32'(dm_we), 32'd0);
    step(); step(); rst = 1'b0;
    run_load("LW", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    run_load("LB", 3'b000, 32'h103, 32'h80F17F82, 32'hFFFFFF80);
    run_load("LBU", 3'b100, 32'h101, 32'h80F17F82, 32'h0000007F);
    run_load("LH", 3'b001, 32'h102, 32'h80F17F82, 32'hFFFF80F1);
    run_load("LHU", 3'b100 | 3'b001, 32'h100, 32'h80F17F82, 32'h00007F82);
    run_store("SB", 1'b0, 3'b000, 32'h202, 32'h12345678, 4'b0100, 32'h78787878);
    run_store("SH", 1'b0, 3'b001, 32'h202, 32'h12345678, 4'b1100, 32'h56785678);
    run_store("SW", 1'b0, 3'b010, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    run_store("RW", 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    run_illegal("LW mis", 1'b1, 1'b0, 3'b010, 32'h101);
    run_illegal("LH mis", 1'b1, 1'b0, 3'b001, 32'h103);
    run_illegal("L f3=011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_illegal("S f3=100", 1'b0, 1'b1, 3'b100, 32'h100);
    // ready arrives in cycle 5 after the access is seen
    step(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; dm_rdata = 32'h11223344; dm_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) break;
      n++;
      step();
      if (c == 4) dm_ready = 1'b1;
    end
    chk("wait stall cycles", 32'(n), 32'd6);
    chk("wait ld_valid", 32'(ld_valid), 32'd1);
    chk("wait ld_data", ld_data, 32'h11223344);
    pulse_rst();
    step(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; dm_ready = 1'b0; #1;
    chk("tmo c0 stall", 32'(stall4), 32'd1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      if (!dm_req4) break;
      n++;
    end
    chk("tmo req cycles", 32'(n), 32'd4);
    chk("tmo bus_err", 32'(bus_err4), 32'd1);
    chk("tmo ld_valid", 32'(ld_valid4), 32'd0);
    chk("tmo ld_data", ld_data4, 32'd0);
    chk("tmo stall", 32'(stall4), 32'd0);
    step(); #1;
    chk("tmo bus_err drop", 32'(bus_err4), 32'd0);
    chk("rst mid req", 32'(dm_req), 32'd1);
    #2 rst = 1'b1; #1;
    chk("async req drop", 32'(dm_req), 32'd0);
    chk("async stall drop", 32'(stall), 32'd0);
    idle_inputs();
    step(); #1;
    chk("rst no flags", {29'd0, ld_valid, access_err, bus_err}, 32'd0);
    rst = 1'b0;
    run_load("LW post", 3'b010, 32'h104, 32'h0BADF00D, 32'h0BADF00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the memory stage of the RV32I core. It consumes the memory-stage control decode (`mem_read`, `mem_write`, `funct3`) together with the ALU-computed address and the store data. It runs a request/ready handshake with the data memory and generates byte strobes and load extraction with sign or zero extension. It stalls the pipeline until the access completes, times out, or is rejected as illegal.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles spent waiting for `dm_ready` before the access is aborted. Legal range is 1..255, held in an 8-bit counter.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `mem_read` input 1: the memory-stage instruction is a load.
- `mem_write` input 1: the memory-stage instruction is a store.
- `funct3` input 3: access size/sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr` input 32: byte address.
- `wdata` input 32: store data; low bits are significant.
- `stall` output 1: freezes all stages up to and including the memory stage.
- `ld_valid` output 1: one-cycle pulse; `ld_data` is valid.
- `ld_data` output 32: extended load result.
- `access_err` output 1: one-cycle pulse for a misaligned access or illegal `funct3`.
- `bus_err` output 1: one-cycle pulse when the access timed out.
- `dm_req` output 1: memory request.
- `dm_we` output 1: write enable.
- `dm_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dm_wstrb` output 4: byte-lane write strobes.
- `dm_wdata` output 32: lane-replicated store data.
- `dm_ready` input 1: memory accepted or completed the request this cycle.
- `dm_rdata` input 32: read word, valid in the cycle `dm_ready` is high.

## Operation
**FSM states:** IDLE, REQ, DONE.

**IDLE**
- Access present when `mem_read|mem_write` is high.
- If both are high, the access is a store and `mem_read` is ignored.
- Legality check, all combinational:
  - Illegal `funct3` for a load: 011, 110, 111.
  - Illegal `funct3` for a store: anything other than 000, 001, 010.
  - Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Illegal or misaligned access:
  - `access_err`=1 in that cycle.
  - `stall`=0, no memory request, state stays IDLE.
- Legal access:
  - `stall`=1 combinationally.
  - Latch `dm_addr`, `dm_we`, `dm_wstrb`, `dm_wdata`, `funct3`, `addr[1:0]`; clear the timeout counter.
  - Move to REQ.

**REQ**
- `dm_req`=1, `stall`=1; all `dm_*` outputs held stable.
- `dm_ready`=1: capture `dm_rdata` if the access is a load, then go to DONE.
- Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 with no ready, go to DONE with an abort flag set.

**DONE**
- `stall`=0, lasting exactly one cycle.
- Load, not aborted: `ld_valid`=1.
- Aborted: `bus_err`=1, `ld_valid`=0, `ld_data`=0.
- Next state is IDLE. Memory-stage inputs present during DONE belong to the completing instruction and are ignored.

**Store lanes**
- SB: `dm_wstrb`=`4'b0001<<addr[1:0]`, `dm_wdata`=`{4{wdata[7:0]}}`.
- SH: `dm_wstrb`=`addr[1]`?`1100`:`0011`, `dm_wdata`=`{2{wdata[15:0]}}`.
- SW: `dm_wstrb`=`1111`, `dm_wdata`=`wdata`.
- Loads drive `dm_wstrb`=0 and `dm_wdata`=0.

**Load extraction**
- Select the byte at `addr[1:0]` or the halfword at `addr[1]`.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.

## Timing
**Reset**
- IDLE.
- All outputs 0, including `stall` and `dm_req`.
- Counter 0.

**Reset asserted mid-access**
- Drops `dm_req` and `stall` immediately, because reset is asynchronous.
- No `ld_valid` or `bus_err` is produced.

**Latency**
- Access seen in cycle 0, `dm_ready` high in cycle 1: `ld_valid` in cycle 2.
- `stall` is high in cycles 0–1.
- Each extra wait cycle adds one cycle.

**`dm_ready` outside REQ** is ignored.

**Timeout**
- `dm_req` stays high for exactly `TIMEOUT` cycles, then `bus_err` pulses in the following cycle.
- `dm_ready` arriving in the last REQ cycle wins over the timeout.

**Back-to-back accesses**
- The next access is first examined in the cycle after DONE.
- Minimum spacing is 3 cycles per access.

**Output width**
- `ld_valid`, `access_err`, and `bus_err` are never high for more than one cycle per access.
- At most one of the three is high in any cycle.

## Test plan
- **Load word:** LW with `addr`=0x100 and `dm_ready` tied to 1.
  - Expect `dm_req` in cycle 1, `dm_addr`=0x100, `dm_wstrb`=0.
  - Expect `ld_valid` in cycle 2 with `ld_data`=`dm_rdata`=0xDEADBEEF.
  - Expect `stall` high in cycles 0–1 only.
- **Byte and halfword loads:** `dm_rdata`=0x80F17F82.
  - LB at `addr` 0x103 gives 0xFFFFFF80.
  - LBU at 0x101 gives 0x0000007F.
  - LH at 0x102 gives 0xFFFF80F1.
  - LHU at 0x100 gives 0x00007F82.
- **Stores:**
  - SB `wdata`=0x12345678 at 0x202: `dm_wstrb`=0100, `dm_wdata`=0x78787878, `dm_we`=1.
  - SH at 0x202: `dm_wstrb`=1100, `dm_wdata`=0x56785678.
- **Illegal accesses:**
  - LW at 0x101 gives an `access_err` pulse, no `dm_req`, `stall`=0.
  - `funct3`=011 with `mem_read` gives `access_err`.
  - `mem_read`=`mem_write`=1 performs a store.
- **Wait states and timeout:**
  - `dm_ready` delayed 5 cycles: `stall` held for 6 cycles, then `ld_valid`.
  - `TIMEOUT`=4 with no ready: `dm_req` high 4 cycles, then `bus_err` pulse and `ld_data`=0.
- **Reset mid-access:** assert `rst` during REQ.
  - `dm_req`=0 and `stall`=0 asynchronously.
  - After release, a new LW completes normally.
